// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters: requester 0
// is the main instruction datapath and requester 1 is the branch/address
// helper. A round-robin grant picks one requester at a time. Requests and
// responses use a valid/ready handshake. Operands and the result are held in
// registers. Every operation passes through IDLE -> EXEC -> RESP -> IDLE.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req_valid  in   [1:0]   bit i: requester i presents an operation
//   req_ready  out  [1:0]   bit i: requester i is accepted this cycle
//   req_in1    in   [2W-1:0] operand 1, requester i in [i*W +: W]
//   req_in2    in   [2W-1:0] operand 2, same packing
//   req_ctrl   in   [9:0]   5-bit ALU opcode, requester i in [i*5 +: 5]
//   req_sign   in   [1:0]   signed-compare select per requester
//   rsp_valid  out  [1:0]   bit i: result for requester i is available
//   rsp_ready  in   [1:0]   bit i: requester i consumes the result
//   rsp_out    out  [W-1:0] result word, shared by both requesters
//   rsp_zero   out  zero flag of the result
//   alu_in1    out  [W-1:0] to ALU operand 1
//   alu_in2    out  [W-1:0] to ALU operand 2
//   alu_ctrl   out  [4:0]   to ALU opcode
//   alu_sign   out  to ALU sign select
//   alu_out    in   [W-1:0] from ALU result
//   alu_zero   in   from ALU zero flag
//   busy       out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_in1,
    input  logic [2*WIDTH-1:0] req_in2,
    input  logic [9:0]         req_ctrl,
    input  logic [1:0]         req_sign,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_out,
    output logic               rsp_zero,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [4:0]         alu_ctrl,
    output logic               alu_sign,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_zero,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic               prio_q;
    logic               grant_q;
    logic [WIDTH-1:0]   in1_q;
    logic [WIDTH-1:0]   in2_q;
    logic [4:0]         ctrl_q;
    logic               sign_q;
    logic [WIDTH-1:0]   rspOut_q;
    logic               rspZero_q;
    logic [1:0]         rspValid_q;
    logic               busy_q;

    // Candidate grant and the operands it would latch on accept
    logic               selIdx_d;
    logic               accept_d;
    logic [WIDTH-1:0]   in1_d;
    logic [WIDTH-1:0]   in2_d;
    logic [4:0]         ctrl_d;
    logic               sign_d;

    // Round-robin pick: a lone requester always wins; a tie goes to prio_q.
    // req_ready is gated with reset so nothing is offered while reset is held,
    // even though the FSM already sits in IDLE.
    always_comb begin
        selIdx_d  = (req_valid == 2'b11) ? prio_q : req_valid[1];
        req_ready = 2'b00;
        if (reset && (state_q == IDLE) && (req_valid != 2'b00)) begin
            req_ready[selIdx_d] = 1'b1;
        end
        accept_d = |(req_valid & req_ready);
    end

    // Operand select for the chosen requester. This uses explicit muxes
    // rather than computed part-selects.
    always_comb begin
        in1_d  = selIdx_d ? req_in1[WIDTH +: WIDTH] : req_in1[0 +: WIDTH];
        in2_d  = selIdx_d ? req_in2[WIDTH +: WIDTH] : req_in2[0 +: WIDTH];
        ctrl_d = selIdx_d ? req_ctrl[9:5] : req_ctrl[4:0];
        sign_d = selIdx_d ? req_sign[1] : req_sign[0];
    end

    // Main FSM. All outputs except req_ready are registered here. Priority
    // flips only on an accept, toward the requester that was not served.
    // The response is only released by the granted requester's rsp_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prio_q     <= PRIO_INIT;
            grant_q    <= 1'b0;
            in1_q      <= '0;
            in2_q      <= '0;
            ctrl_q     <= '0;
            sign_q     <= 1'b0;
            rspOut_q   <= '0;
            rspZero_q  <= 1'b0;
            rspValid_q <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        in1_q   <= in1_d;
                        in2_q   <= in2_d;
                        ctrl_q  <= ctrl_d;
                        sign_q  <= sign_d;
                        grant_q <= selIdx_d;
                        prio_q  <= ~selIdx_d;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rspOut_q   <= alu_out;
                    rspZero_q  <= alu_zero;
                    rspValid_q <= {grant_q, ~grant_q};
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rspValid_q <= 2'b00;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    rspValid_q <= 2'b00;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_ctrl  = ctrl_q;
    assign alu_sign  = sign_q;
    assign rsp_out   = rspOut_q;
    assign rsp_zero  = rspZero_q;
    assign rsp_valid = rspValid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Testbench for alu_arbiter. The bench supplies a behavioural stand-in for
// the shared ALU. It keeps a small reference model of the round-robin
// priority. It predicts every grant and every result from the request
// fields alone.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_in1;
    logic [2*W-1:0] req_in2;
    logic [9:0]     req_ctrl;
    logic [1:0]     req_sign;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_out;
    logic           rsp_zero;
    logic [W-1:0]   alu_in1;
    logic [W-1:0]   alu_in2;
    logic [4:0]     alu_ctrl;
    logic           alu_sign;
    logic [W-1:0]   alu_out;
    logic           alu_zero;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    // Per-requester operation fields, driven onto the packed request buses
    logic [W-1:0] opA   [2];
    logic [W-1:0] opB   [2];
    logic [4:0]   opCode[2];
    logic         opSign[2];

    // Reference priority: the requester that wins a tie
    int prioModel;

    alu_arbiter #(.WIDTH(W), .PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_ctrl  (req_ctrl),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_ctrl  (alu_ctrl),
        .alu_sign  (alu_sign),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .busy      (busy)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. Opcodes 14 and above return 1.
    function automatic logic [W-1:0] refAlu(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [4:0] c, input logic s);
        logic [W-1:0] r;
        case (c)
            5'd0:    r = x + y;
            5'd1:    r = x - y;
            5'd2:    r = x & y;
            5'd3:    r = x | y;
            5'd4:    r = x ^ y;
            5'd5:    r = x << y[4:0];
            5'd6:    r = x >> y[4:0];
            5'd7:    r = $signed(x) >>> y[4:0];
            5'd8:    r = ~(x | y);
            5'd9:    r = s ? {31'b0, ($signed(x) < $signed(y))} : {31'b0, (x < y)};
            5'd10:   r = y;
            5'd11:   r = x;
            5'd12:   r = x + 32'd1;
            5'd13:   r = {y[15:0], 16'h0000};
            default: r = 32'd1;
        endcase
        return r;
    endfunction

    // The ALU stand-in only ever sees what the arbiter drives out
    always_comb begin
        alu_out  = refAlu(alu_in1, alu_in2, alu_ctrl, alu_sign);
        alu_zero = (alu_out == '0);
    end

    // Drive request and response-ready inputs from the per-requester fields
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy);
        req_valid = valid;
        req_in1   = {opA[1], opA[0]};
        req_in2   = {opB[1], opB[0]};
        req_ctrl  = {opCode[1], opCode[0]};
        req_sign  = {opSign[1], opSign[0]};
        rsp_ready = rdy;
    endtask

    // One comparison. A mismatch is counted and reported, and the run goes on.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full transaction, entered and left on a falling edge. The grant comes
    // from the round-robin rules. The result comes from the request fields.
    // During a stall the non-granted rsp_ready bit toggles. It must be ignored.
    task automatic runOp(input logic [1:0] valid, input int stall);
        int           g;
        logic [1:0]   oh;
        logic [W-1:0] expOut;
        g      = (valid == 2'b11) ? prioModel : (valid[1] ? 1 : 0);
        oh     = (g == 1) ? 2'b10 : 2'b01;
        expOut = refAlu(opA[g], opB[g], opCode[g], opSign[g]);

        applyStimulus(valid, 2'b00);
        #1;
        checkOutput("idle_req_ready", req_ready, oh);
        checkOutput("idle_busy", busy, 0);
        @(posedge clk);
        prioModel = 1 - g;

        // EXEC: the registered operands are on the ALU port
        @(negedge clk);
        checkOutput("exec_req_ready", req_ready, 0);
        checkOutput("exec_busy", busy, 1);
        checkOutput("exec_rsp_valid", rsp_valid, 0);
        checkOutput("exec_alu_in1", alu_in1, opA[g]);
        checkOutput("exec_alu_in2", alu_in2, opB[g]);
        checkOutput("exec_alu_ctrl", alu_ctrl, opCode[g]);
        checkOutput("exec_alu_sign", alu_sign, opSign[g]);

        // RESP: the result is registered and offered to the granted requester only
        @(negedge clk);
        checkOutput("resp_rsp_valid", rsp_valid, oh);
        checkOutput("resp_rsp_out", rsp_out, expOut);
        checkOutput("resp_rsp_zero", rsp_zero, (expOut == '0));
        checkOutput("resp_req_ready", req_ready, 0);

        for (int i = 0; i < stall; i++) begin
            applyStimulus(valid, (i % 2 == 1) ? ~oh : 2'b00);
            @(negedge clk);
            checkOutput("stall_rsp_valid", rsp_valid, oh);
            checkOutput("stall_rsp_out", rsp_out, expOut);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_busy", busy, 1);
        end

        applyStimulus(valid, oh);
        @(negedge clk);
        checkOutput("done_rsp_valid", rsp_valid, 0);
        checkOutput("done_busy", busy, 0);
        applyStimulus(2'b00, 2'b00);
    endtask

    task automatic setOp(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] c, input logic s);
        opA[r]    = a;
        opB[r]    = b;
        opCode[r] = c;
        opSign[r] = s;
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed steps, then a randomized run, then reset in the middle of an operation
    initial begin
        prioModel = 0;
        setOp(0, 32'h1111_0000, 32'h2, 5'd3, 1'b0);
        setOp(1, 32'h0000_2222, 32'h3, 5'd4, 1'b1);
        reset = 1'b0;
        applyStimulus(2'b11, 2'b11);
        repeat (2) @(negedge clk);

        // Reset state. Both requests are valid, but none may be accepted.
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_out", rsp_out, 0);
        checkOutput("rst_rsp_zero", rsp_zero, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl, 0);
        checkOutput("rst_alu_in1", alu_in1, 0);
        applyStimulus(2'b00, 2'b00);
        reset = 1'b1;
        @(negedge clk);

        // ADD on requester 0, then SUB to zero on requester 1
        setOp(0, 32'd5, 32'd7, 5'd0, 1'b0);
        runOp(2'b01, 0);
        setOp(1, 32'd9, 32'd9, 5'd1, 1'b0);
        runOp(2'b10, 0);

        // Continuous dual requests alternate 0,1,0,1
        setOp(0, 32'd100, 32'd1, 5'd1, 1'b0);
        setOp(1, 32'hF0F0_0000, 32'h0F0F_FFFF, 5'd3, 1'b0);
        for (int i = 0; i < 4; i++) runOp(2'b11, 0);

        // Signed and unsigned set-less-than
        setOp(0, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1);
        runOp(2'b01, 0);
        setOp(0, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b0);
        runOp(2'b01, 0);

        // Backpressure: ten stalled cycles with both requests pending
        setOp(0, 32'h8000_0000, 32'd4, 5'd7, 1'b0);
        setOp(1, 32'd3, 32'd6, 5'd20, 1'b0);
        runOp(2'b11, 10);
        runOp(2'b11, 10);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            for (int r = 0; r < 2; r++) begin
                setOp(r, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) opB[r] = opA[r];
            end
            runOp(2'($urandom_range(1, 3)), $urandom_range(0, 3));
        end

        // Reset during EXEC. First leave a nonzero result and priority on 0.
        setOp(1, 32'd5, 32'd7, 5'd0, 1'b0);
        runOp(2'b10, 0);
        setOp(0, 32'd40, 32'd2, 5'd0, 1'b0);
        applyStimulus(2'b11, 2'b00);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_rsp_out", rsp_out, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        checkOutput("midrst_alu_in1", alu_in1, 0);
        checkOutput("midrst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        reset = 1'b1;
        prioModel = 0;
        applyStimulus(2'b00, 2'b00);
        repeat (3) begin
            @(negedge clk);
            checkOutput("postrst_no_rsp", rsp_valid, 0);
        end

        // Priority is back at requester 0 for a tie
        setOp(0, 32'd11, 32'd22, 5'd0, 1'b0);
        setOp(1, 32'd50, 32'd8, 5'd1, 1'b0);
        runOp(2'b11, 0);
        runOp(2'b10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters:
  - requester 0: the main instruction datapath;
  - requester 1: the branch/address helper.
- Uses a round-robin grant, a valid/ready handshake on request and response, and registered operands and result.
- Sits between the requesters and the ALU instance. It drives the ALU's operand and control inputs and captures its out/zero outputs.

Parameters:
- WIDTH, 32, operand/result width. Must match the ALU datapath.
- PRIO_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: the arbiter accepts requester i this cycle.
- req_in1  input  2*WIDTH  requester i operand 1 in bits [i*WIDTH +: WIDTH].
- req_in2  input  2*WIDTH  requester i operand 2, same packing.
- req_ctrl  input  10  requester i 5-bit ALU opcode in bits [i*5 +: 5].
- req_sign  input  2  bit i: signed compare select for requester i.
- rsp_valid  output  2  bit i: result for requester i is available.
- rsp_ready  input  2  bit i: requester i consumes the result.
- rsp_out  output  WIDTH  result word, shared by both requesters.
- rsp_zero  output  1  zero flag of the result.
- alu_in1  output  WIDTH  to ALU operand 1.
- alu_in2  output  WIDTH  to ALU operand 2.
- alu_ctrl  output  5  to ALU opcode.
- alu_sign  output  1  to ALU sign select.
- alu_out  input  WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero flag.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE, prio=PRIO_INIT, grant=0.
  - Operand/ctrl/sign registers = 0, so alu_ctrl=0 (ADD).
  - rsp_out=0, rsp_zero=0, rsp_valid=0, req_ready=0, busy=0.
  - Any in-flight operation is dropped; no response is ever issued for it.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant selection is combinational. If only one req_valid bit is set, that requester is selected. If both are set, requester prio is selected.
  - req_ready is one-hot on the selected requester and zero if none is valid.
  - On accept (req_valid[g] & req_ready[g]): latch in1/in2/ctrl/sign of g into the operand registers, grant<=g, prio<=~g, go to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU sees the registered operands.
  - At the clock edge: rsp_out<=alu_out, rsp_zero<=alu_zero, go to RESP.
- RESP:
  - rsp_valid[grant]=1; the other bit is 0.
  - On rsp_ready[grant]=1: go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
  - rsp_out and rsp_zero hold stable until the handshake completes.
- req_ready=0 in EXEC and RESP. A requester must hold req_valid and its operands stable until accepted.
- Latency: accept edge k, result registered at edge k+1, rsp_valid high from cycle k+1 onward. Minimum 3 cycles per operation.
- Fairness:
  - prio flips only on an accept, toward the non-granted requester.
  - With continuous dual requests, grants strictly alternate: 0,1,0,1… when PRIO_INIT=0.
  - A single requester with the other idle is granted back-to-back.
- Operand registers keep their last value in IDLE. The ALU output is not observed outside EXEC.
- No arithmetic in this block: opcode, width and sign semantics are entirely the ALU's. Results pass through unmodified.
- Opcodes ≥14 are forwarded unchanged; the ALU returns 1 for them.

Test Plan:
1. ADD: reset, release; req0 only, in1=5, in2=7, ctrl=0.
   - req_ready=01 in the same cycle.
   - rsp_valid=01 one cycle after accept, rsp_out=12, rsp_zero=0.
   - rsp_ready=01 returns to IDLE, busy=0.
2. SUB: req1 only, in1=9, in2=9, ctrl=1.
   - rsp_valid=10, rsp_out=0, rsp_zero=1.
3. Arbitration: both valid continuously with PRIO_INIT=0, four operations.
   - Grant order 0,1,0,1; req_ready is never 11.
   - Each rsp_valid goes only to the granted requester.
4. Signed SLT: req0 in1=32'hFFFFFFFF, in2=1, ctrl=9.
   - With sign=1: rsp_out=1.
   - Repeated with sign=0: rsp_out=0.
5. Backpressure: hold rsp_ready=00 for 10 cycles in RESP.
   - rsp_valid and rsp_out stay stable; req_ready=00 despite req_valid=11.
   - Asserting the non-granted rsp_ready bit has no effect.
6. Reset mid-operation: assert reset asynchronously during EXEC.
   - All outputs go to 0 immediately.
   - After release, a new request on either port completes normally with priority back at PRIO_INIT.
